// File: rtl/des_round_sequencer_if.sv
// -----------------------------------------------------------------------------
// des_round_sequencer_if
// Purpose : Groups the handshake between the DES round sequencer, the input
//           controller, the external round unit, the FP capture stage and the
//           result consumer.
// Signals : start     input-controller level (inputComplete), rising edge = run
//           mode      0 = encrypt, 1 = decrypt (only used with DES_DECRYPT_EN)
//           ip_load   1-cycle pulse, load data through IP and key through PC-1
//           rnd_go    1-cycle pulse, round unit starts round rnd_num
//           rnd_num   current round index, stable from rnd_go to rnd_done
//           rnd_shift key-half rotate amount for the current round (0/1/2)
//           rnd_dir   rotate direction, 0 = left, 1 = right
//           rnd_done  1-cycle pulse from round unit, round finished
//           fp_load   1-cycle pulse, capture swapped R16L16 through FP
//           busy      high from LOAD through FINAL
//           done      result valid, held until res_ack
//           error     round-unit timeout, held until res_ack
//           res_ack   consumer acknowledge of done/error
// Modports: master = sequencer side, slave = surrounding datapath/controller.
// -----------------------------------------------------------------------------
interface des_round_sequencer_if;
    logic       start;
    logic       mode;
    logic       ip_load;
    logic       rnd_go;
    logic [3:0] rnd_num;
    logic [1:0] rnd_shift;
    logic       rnd_dir;
    logic       rnd_done;
    logic       fp_load;
    logic       busy;
    logic       done;
    logic       error;
    logic       res_ack;

    modport master (
        input  start, mode, rnd_done, res_ack,
        output ip_load, rnd_go, rnd_num, rnd_shift, rnd_dir,
               fp_load, busy, done, error
    );

    modport slave (
        output start, mode, rnd_done, res_ack,
        input  ip_load, rnd_go, rnd_num, rnd_shift, rnd_dir,
               fp_load, busy, done, error
    );
endinterface

// File: rtl/des_round_sequencer.sv
// -----------------------------------------------------------------------------
// des_round_sequencer
// Purpose : Once keyboard entry of data/key is complete, pulses IP/PC-1 load,
//           issues ROUNDS round requests to the external round unit together
//           with the key-schedule shift for each round, then pulses the
//           final-permutation capture. The result flag (done or error) is held
//           for the display until the consumer acknowledges it.
// Ports   : clk  system clock
//           rst  asynchronous, active-low reset
//           bus  des_round_sequencer_if.master (see interface header)
// Params  : ROUNDS        number of Feistel rounds issued (2..16)
//           ROUND_TIMEOUT max WAIT_RND cycles counted before ERROR (8-bit)
// Config  : DES_DECRYPT_EN - when defined, mode is latched on the starting
//           edge and selects the decrypt key schedule (right rotates, shift 0
//           on round 0). When undefined, mode is ignored and rnd_dir is 0.
// -----------------------------------------------------------------------------
module des_round_sequencer #(
    parameter int ROUNDS        = 16,
    parameter int ROUND_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    des_round_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_RND,
        S_FINAL,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [3:0] LAST_RND    = 4'(ROUNDS - 1);
    localparam logic [7:0] TIMEOUT_CNT = 8'(ROUND_TIMEOUT);

    state_t     r_state;
    logic       r_start_q;
    logic [3:0] r_rnd_num;
    logic [7:0] r_cnt;
    logic       r_ip_load;
    logic       r_rnd_go;
    logic       r_fp_load;
    logic       r_busy;
    logic       r_done;
    logic       r_error;

    logic       w_start_rise;
    logic [1:0] w_shift;
    logic       w_dir;

    // A start level that stays high never retriggers: only a fresh edge counts.
    assign w_start_rise = bus.start & ~r_start_q;

    // Encrypt schedule: single rotate on rounds 0,1,8,15, double elsewhere.
    function automatic logic [1:0] enc_shift(input logic [3:0] rnd);
        logic [1:0] sh;
        case (rnd)
            4'd0, 4'd1, 4'd8, 4'd15: sh = 2'd1;
            default:                 sh = 2'd2;
        endcase
        return sh;
    endfunction

    // Decrypt schedule: the key after PC-1 already equals K16's C/D halves,
    // so round 0 needs no rotation; the rest mirror the encrypt table.
    function automatic logic [1:0] dec_shift(input logic [3:0] rnd);
        logic [1:0] sh;
        case (rnd)
            4'd0:                    sh = 2'd0;
            4'd1, 4'd8, 4'd15:       sh = 2'd1;
            default:                 sh = 2'd2;
        endcase
        return sh;
    endfunction

`ifdef DES_DECRYPT_EN
    logic r_mode_q;

    // Mode is captured only on the starting edge so mid-run changes are inert.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode_q <= 1'b0;
        end else if (r_state == S_IDLE && w_start_rise) begin
            r_mode_q <= bus.mode;
        end
    end

    always_comb begin
        w_shift = enc_shift(r_rnd_num);
        w_dir   = 1'b0;
        if (r_mode_q) begin
            w_shift = dec_shift(r_rnd_num);
            w_dir   = 1'b1;
        end
    end
`else
    always_comb begin
        w_shift = enc_shift(r_rnd_num);
        w_dir   = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b0;
            r_rnd_num <= 4'd0;
            r_cnt     <= 8'd0;
            r_ip_load <= 1'b0;
            r_rnd_go  <= 1'b0;
            r_fp_load <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_start_q <= bus.start;
            // Pulse outputs default low; each is raised on entry to its state.
            r_ip_load <= 1'b0;
            r_rnd_go  <= 1'b0;
            r_fp_load <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_start_rise) begin
                        r_state   <= S_LOAD;
                        r_ip_load <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end

                S_LOAD: begin
                    r_rnd_num <= 4'd0;
                    r_rnd_go  <= 1'b1;
                    r_state   <= S_ISSUE;
                end

                S_ISSUE: begin
                    r_cnt   <= 8'd0;
                    r_state <= S_WAIT_RND;
                end

                S_WAIT_RND: begin
                    // A finishing round beats a timeout reached in the same cycle.
                    if (bus.rnd_done) begin
                        if (r_rnd_num == LAST_RND) begin
                            r_fp_load <= 1'b1;
                            r_state   <= S_FINAL;
                        end else begin
                            r_rnd_num <= r_rnd_num + 4'd1;
                            r_rnd_go  <= 1'b1;
                            r_state   <= S_ISSUE;
                        end
                    end else if (r_cnt == TIMEOUT_CNT) begin
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                        r_state <= S_ERROR;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_FINAL: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end

                S_DONE: begin
                    if (bus.res_ack) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                S_ERROR: begin
                    if (bus.res_ack) begin
                        r_error <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ip_load   = r_ip_load;
    assign bus.rnd_go    = r_rnd_go;
    assign bus.rnd_num   = r_rnd_num;
    // Shift/direction are only meaningful during a run; keep them quiet otherwise.
    assign bus.rnd_shift = r_busy ? w_shift : 2'd0;
    assign bus.rnd_dir   = r_busy & w_dir;
    assign bus.fp_load   = r_fp_load;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.error     = r_error;

endmodule

// File: tb/tb_des_round_sequencer.sv
module tb_des_round_sequencer;

    localparam int ROUNDS = 16;
`ifdef DES_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   cyc;
    int   errors;
    int   checks;
    int   run_dly [ROUNDS];

    des_round_sequencer_if bus_if ();

    des_round_sequencer #(
        .ROUNDS       (ROUNDS),
        .ROUND_TIMEOUT(255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Key-schedule rule written straight from the DES round table.
    function automatic int exp_shift(input int r, input bit dec);
        if (dec && r == 0) return 0;
        if (r == 0 || r == 1 || r == 8 || r == 15) return 1;
        return 2;
    endfunction

    // Drives one run from a fresh start edge and checks every observed event
    // against timing predicted from the per-round rnd_done delays in run_dly.
    // Must be entered just after a posedge (+#1) with start low.
    // stop_round : round whose rnd_done is withheld (expect timeout), -1 none
    // abort_round: return as soon as this round's rnd_go is seen, -1 none
    // spur       : inject rnd_done in LOAD/ISSUE and stray res_ack pulses
    task automatic do_run(input bit md, input int stop_round,
                          input int abort_round, input bit spur);
        int  t0, exp_go, exp_fp, exp_err, k, pend, n_ip, n_fp;
        bit  finished;
        bit  exp_dir;
        exp_dir  = DEC_EN ? md : 1'b0;
        bus_if.mode  = md;
        bus_if.start = 1'b1;
        t0       = cyc;
        exp_go   = t0 + 2;
        exp_fp   = -1;
        exp_err  = -1;
        k        = 0;
        pend     = -1;
        n_ip     = 0;
        n_fp     = 0;
        finished = 1'b0;
        for (int i = 0; i < 6000 && !finished; i++) begin
            @(posedge clk); #1;
            bus_if.rnd_done = (cyc == pend);
            bus_if.res_ack  = spur ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (k >= 4) bus_if.mode = ~md;
            if (bus_if.ip_load) begin
                n_ip++;
                checks++;
                if (cyc !== t0 + 1 || bus_if.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL ip_load: cyc=%0d busy=%0b want cyc=%0d busy=1",
                             cyc, bus_if.busy, t0 + 1);
                end
                if (spur) bus_if.rnd_done = 1'b1;
            end
            if (bus_if.rnd_go) begin
                checks++;
                if (cyc !== exp_go || bus_if.rnd_num !== 4'(k)) begin
                    errors++;
                    $display("FAIL rnd_go_%0d: cyc=%0d num=%0d want cyc=%0d num=%0d",
                             k, cyc, bus_if.rnd_num, exp_go, k);
                end
                checks++;
                if (bus_if.rnd_shift !== 2'(exp_shift(k, exp_dir)) ||
                    bus_if.rnd_dir !== exp_dir || bus_if.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL sched_%0d: shift=%0d dir=%0b busy=%0b want shift=%0d dir=%0b busy=1",
                             k, bus_if.rnd_shift, bus_if.rnd_dir, bus_if.busy,
                             exp_shift(k, exp_dir), exp_dir);
                end
                if (k == abort_round) begin
                    finished = 1'b1;
                end else if (k == stop_round) begin
                    exp_err = cyc + 257;
                end else begin
                    pend = cyc + run_dly[k];
                    if (k == ROUNDS - 1) exp_fp = pend + 1;
                    else                 exp_go = pend + 1;
                    if (spur) bus_if.rnd_done = 1'b1;
                end
                k++;
            end
            if (bus_if.fp_load) begin
                n_fp++;
                checks++;
                if (cyc !== exp_fp || bus_if.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL fp_load: cyc=%0d busy=%0b want cyc=%0d busy=1",
                             cyc, bus_if.busy, exp_fp);
                end
            end
            if (bus_if.done) begin
                finished = 1'b1;
                checks++;
                if (cyc !== exp_fp + 1 || bus_if.busy !== 1'b0 || bus_if.error !== 1'b0) begin
                    errors++;
                    $display("FAIL done_time: cyc=%0d busy=%0b err=%0b want cyc=%0d busy=0 err=0",
                             cyc, bus_if.busy, bus_if.error, exp_fp + 1);
                end
                checks++;
                if (n_ip !== 1 || n_fp !== 1 || k !== ROUNDS || stop_round !== -1) begin
                    errors++;
                    $display("FAIL done_counts: ip=%0d fp=%0d go=%0d want ip=1 fp=1 go=%0d no done",
                             n_ip, n_fp, k, ROUNDS);
                end
            end
            if (bus_if.error) begin
                finished = 1'b1;
                checks++;
                if (cyc !== exp_err || bus_if.rnd_num !== 4'(stop_round) ||
                    n_fp !== 0 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
                    errors++;
                    $display("FAIL error_time: cyc=%0d num=%0d fp=%0d busy=%0b want cyc=%0d num=%0d fp=0 busy=0",
                             cyc, bus_if.rnd_num, n_fp, bus_if.busy, exp_err, stop_round);
                end
            end
        end
        if (!finished) begin
            errors++;
            checks++;
            $display("FAIL run_timeout: rounds seen=%0d want run to finish", k);
        end
        bus_if.rnd_done = 1'b0;
        bus_if.res_ack  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++;
        if ({bus_if.ip_load, bus_if.rnd_go, bus_if.rnd_num, bus_if.rnd_shift, bus_if.rnd_dir,
             bus_if.fp_load, bus_if.busy, bus_if.done, bus_if.error} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%0b done=%0b err=%0b num=%0d want all 0",
                     bus_if.busy, bus_if.done, bus_if.error, bus_if.rnd_num);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.ip_load !== 1'b0 || bus_if.done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%0b ip=%0b done=%0b want 0",
                     bus_if.busy, bus_if.ip_load, bus_if.done);
        end
    endtask

    task automatic ack_result(input string tag);
        bus_if.res_ack = 1'b1;
        @(posedge clk); #1;
        bus_if.res_ack = 1'b0;
        checks++;
        if (bus_if.done !== 1'b0 || bus_if.error !== 1'b0 || bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL ack_%s: done=%0b err=%0b busy=%0b want 0", tag,
                     bus_if.done, bus_if.error, bus_if.busy);
        end
    endtask

    task automatic test_basic_run();
        for (int r = 0; r < ROUNDS; r++) run_dly[r] = 1;
        @(posedge clk); #1;
        do_run(1'b0, -1, -1, 1'b0);
        ack_result("basic");
        bus_if.start = 1'b0;
    endtask

    task automatic test_random_delays();
        for (int n = 0; n < 3; n++) begin
            for (int r = 0; r < ROUNDS; r++) run_dly[r] = $urandom_range(1, 12);
            @(posedge clk); #1;
            do_run(1'($urandom_range(0, 1)), -1, -1, 1'b0);
            ack_result("random");
            bus_if.start = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int n_ip;
        for (int r = 0; r < ROUNDS; r++) run_dly[r] = $urandom_range(1, 4);
        @(posedge clk); #1;
        do_run(1'b0, -1, -1, 1'b0);
        ack_result("hold");
        n_ip = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus_if.ip_load) n_ip++;
        end
        checks++;
        if (n_ip !== 0 || bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL held_start_retrigger: ip_loads=%0d busy=%0b want 0", n_ip, bus_if.busy);
        end
        bus_if.start = 1'b0;
        @(posedge clk); #1;
        do_run(1'b0, -1, -1, 1'b0);
        ack_result("rerun");
        bus_if.start = 1'b0;
    endtask

    task automatic test_timeout();
        for (int r = 0; r < ROUNDS; r++) run_dly[r] = $urandom_range(1, 3);
        @(posedge clk); #1;
        do_run(1'b0, 5, -1, 1'b0);
        checks++;
        if (bus_if.error !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag: err=%0b want 1", bus_if.error);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus_if.error !== 1'b1 || bus_if.fp_load !== 1'b0) begin
            errors++;
            $display("FAIL error_held: err=%0b fp=%0b want err=1 fp=0", bus_if.error, bus_if.fp_load);
        end
        ack_result("error");
        bus_if.start = 1'b0;
    endtask

    task automatic test_ignored_done();
        for (int r = 0; r < ROUNDS; r++) run_dly[r] = $urandom_range(1, 6);
        run_dly[7] = 256;
        @(posedge clk); #1;
        do_run(1'b0, -1, -1, 1'b1);
        ack_result("spur");
        bus_if.start = 1'b0;
    endtask

    task automatic test_reset_midrun();
        for (int r = 0; r < ROUNDS; r++) run_dly[r] = 1;
        @(posedge clk); #1;
        do_run(1'b0, -1, 9, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus_if.ip_load, bus_if.rnd_go, bus_if.rnd_num, bus_if.rnd_shift, bus_if.rnd_dir,
             bus_if.fp_load, bus_if.busy, bus_if.done, bus_if.error} !== 13'd0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%0b num=%0d shift=%0d done=%0b err=%0b want all 0",
                     bus_if.busy, bus_if.rnd_num, bus_if.rnd_shift, bus_if.done, bus_if.error);
        end
        bus_if.start = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_run(1'b0, -1, -1, 1'b0);
        ack_result("after_reset");
        bus_if.start = 1'b0;
    endtask

    task automatic test_mode();
        for (int r = 0; r < ROUNDS; r++) run_dly[r] = $urandom_range(1, 5);
        @(posedge clk); #1;
        do_run(1'b1, -1, -1, 1'b0);
        ack_result("mode");
        bus_if.start = 1'b0;
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        rst             = 1'b0;
        bus_if.start    = 1'b0;
        bus_if.mode     = 1'b0;
        bus_if.rnd_done = 1'b0;
        bus_if.res_ack  = 1'b0;
        test_reset();
        test_basic_run();
        test_random_delays();
        test_back_to_back();
        test_timeout();
        test_ignored_done();
        test_reset_midrun();
        test_mode();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
